// File: rtl/rabbit_pkg.sv
//------------------------------------------------------------------------------
// rabbit_pkg
//   Shared definitions for the Rabbit initialisation engine: counter
//   constants, FSM state encoding and small word-manipulation helpers.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rabbit_pkg;

  localparam int unsigned ITER_DEFAULT = 4;

  // Counter increment constants, repeating with period 3 across j
  localparam logic [31:0] C_A0 = 32'h4D34D34D;
  localparam logic [31:0] C_A1 = 32'hD34D34D3;
  localparam logic [31:0] C_A2 = 32'h34D34D34;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CNT   = 3'd2,
    ST_G     = 3'd3,
    ST_XUPD  = 3'd4,
    ST_CFIX  = 3'd5,
    ST_IVMIX = 3'd6,
    ST_DONE  = 3'd7
  } state_t;

  function automatic logic [31:0] a_const(input logic [2:0] j);
    case (j)
      3'd0, 3'd3, 3'd6: a_const = C_A0;
      3'd1, 3'd4, 3'd7: a_const = C_A1;
      default:          a_const = C_A2;
    endcase
  endfunction

  function automatic logic [31:0] rotl32(input logic [31:0] v, input logic [4:0] n);
    rotl32 = (v << n) | (v >> (6'd32 - {1'b0, n}));
  endfunction

  // K_i = key[16i+15:16i]; the 3-bit index gives the mod-8 wrap for free
  function automatic logic [15:0] key_word(input logic [127:0] key, input logic [2:0] i);
    key_word = key[{i, 4'd0} +: 16];
  endfunction

  // IV words I0..I3 folded onto the counters in the IV phase
  function automatic logic [31:0] iv_word(input logic [63:0] iv, input logic [1:0] n);
    case (n)
      2'd0:    iv_word = iv[31:0];
      2'd1:    iv_word = {iv[63:48], iv[31:16]};
      2'd2:    iv_word = iv[63:32];
      default: iv_word = {iv[47:32], iv[15:0]};
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/rabbit_g_func.sv
//------------------------------------------------------------------------------
// rabbit_g_func
//   Combinational Rabbit g-function: u = x + c (mod 2^32), square to 64 bits,
//   fold high and low halves with XOR.
//   Ports: i_x, i_c (32b operands) -> o_g (32b result)
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rabbit_g_func (
  input  logic [31:0] i_x,
  input  logic [31:0] i_c,
  output logic [31:0] o_g
);

  logic [31:0] w_u;
  logic [63:0] w_sq;

  assign w_u  = i_x + i_c;
  assign w_sq = {32'd0, w_u} * {32'd0, w_u};
  assign o_g  = w_sq[63:32] ^ w_sq[31:0];

endmodule

`default_nettype wire

// File: rtl/rabbit_key_iv_setup.sv
//------------------------------------------------------------------------------
// rabbit_key_iv_setup
//   Rabbit initialisation engine: key expansion, ITER next-state iterations,
//   counter re-mix and optional 64-bit IV setup. The post-key master state is
//   kept so later IVs can be applied without repeating key setup.
//   Ports:
//     clk, rst              clock, async active-high reset
//     i_start_key/i_start_iv start pulses (key wins if both)
//     i_key[127:0], i_iv[63:0], i_iv_en  operands sampled on acceptance
//     o_busy, o_done        activity / one-cycle completion pulse
//     o_master_valid        saved master state present
//     o_err                 one-cycle pulse on rejected start_iv
//     o_x_state, o_c_state, o_carry  working state (valid on o_done)
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rabbit_key_iv_setup
  import rabbit_pkg::*;
#(
  parameter int ITER    = ITER_DEFAULT,
  parameter int G_LANES = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start_key,
  input  logic         i_start_iv,
  input  logic [127:0] i_key,
  input  logic [63:0]  i_iv,
  input  logic         i_iv_en,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_master_valid,
  output logic         o_err,
  output logic [255:0] o_x_state,
  output logic [255:0] o_c_state,
  output logic         o_carry
);

  localparam int P = 8 / G_LANES;

  state_t           r_state, w_next;
  logic [7:0][31:0] r_x, r_c, r_g, r_mx, r_mc;
  logic             r_carry, r_mcarry, r_mvalid, r_err, r_iv_en, r_iv_phase;
  logic [127:0]     r_key;
  logic [63:0]      r_iv;
  logic [3:0]       r_iter;
  logic [2:0]       r_gk;

  logic             w_accept_key, w_accept_iv, w_reject, w_busy, w_done;
  logic [7:0][31:0] w_load_x, w_load_c, w_cnt_c, w_xn, w_cfix_c, w_ivmix_c;
  logic             w_cnt_carry;

  logic [2:0]  w_lane_idx [G_LANES];
  logic [31:0] w_lane_x   [G_LANES];
  logic [31:0] w_lane_c   [G_LANES];
  logic [31:0] w_lane_g   [G_LANES];

  // Lane l of sweep step k serves word j = k*G_LANES + l
  for (genvar l = 0; l < G_LANES; l++) begin : g_lane
    assign w_lane_idx[l] = 3'(int'(r_gk) * G_LANES + l);
    assign w_lane_x[l]   = r_x[w_lane_idx[l]];
    assign w_lane_c[l]   = r_c[w_lane_idx[l]];
    rabbit_g_func u_g (
      .i_x (w_lane_x[l]),
      .i_c (w_lane_c[l]),
      .o_g (w_lane_g[l])
    );
  end

  // Datapath combinational terms
  always_comb begin : p_dp
    logic [32:0] w_sum;
    logic        w_cy_run;
    w_load_x    = '0;
    w_load_c    = '0;
    w_cnt_c     = '0;
    w_xn        = '0;
    w_cfix_c    = '0;
    w_ivmix_c   = '0;
    w_sum       = '0;
    w_cy_run    = r_carry;
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) begin
        w_load_x[j] = {key_word(r_key, 3'(j + 1)), key_word(r_key, 3'(j))};
        w_load_c[j] = {key_word(r_key, 3'(j + 4)), key_word(r_key, 3'(j + 5))};
        w_xn[j]     = r_g[j] + rotl32(r_g[3'(j + 7)], 5'd16) + rotl32(r_g[3'(j + 6)], 5'd16);
      end else begin
        w_load_x[j] = {key_word(r_key, 3'(j + 5)), key_word(r_key, 3'(j + 4))};
        w_load_c[j] = {key_word(r_key, 3'(j)), key_word(r_key, 3'(j + 1))};
        w_xn[j]     = r_g[j] + rotl32(r_g[3'(j + 7)], 5'd8) + r_g[3'(j + 6)];
      end
      // Ripple carry through all eight counters in one cycle
      w_sum      = {1'b0, r_c[j]} + {1'b0, a_const(3'(j))} + {32'd0, w_cy_run};
      w_cnt_c[j] = w_sum[31:0];
      w_cy_run   = w_sum[32];
      w_cfix_c[j]  = r_c[j] ^ r_x[3'(j + 4)];
      w_ivmix_c[j] = r_c[j] ^ iv_word(r_iv, 2'(j));
    end
    w_cnt_carry = w_cy_run;
  end

  // FSM next-state and Moore outputs
  always_comb begin
    w_next       = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_accept_key = 1'b0;
    w_accept_iv  = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start_key) begin
          w_accept_key = 1'b1;
          w_next       = ST_LOAD;
        end else if (i_start_iv) begin
          if (r_mvalid) begin
            w_accept_iv = 1'b1;
            w_next      = ST_IVMIX;
          end else begin
            w_reject = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        w_busy = 1'b1;
        w_next = ST_CNT;
      end
      ST_CNT: begin
        w_busy = 1'b1;
        w_next = ST_G;
      end
      ST_G: begin
        w_busy = 1'b1;
        if (r_gk == 3'(P - 1)) w_next = ST_XUPD;
      end
      ST_XUPD: begin
        w_busy = 1'b1;
        if (r_iter == 4'(ITER - 1)) w_next = r_iv_phase ? ST_DONE : ST_CFIX;
        else                        w_next = ST_CNT;
      end
      ST_CFIX: begin
        w_busy = 1'b1;
        w_next = r_iv_en ? ST_IVMIX : ST_DONE;
      end
      ST_IVMIX: begin
        w_busy = 1'b1;
        w_next = ST_CNT;
      end
      ST_DONE: begin
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x        <= '0;
      r_c        <= '0;
      r_g        <= '0;
      r_mx       <= '0;
      r_mc       <= '0;
      r_carry    <= 1'b0;
      r_mcarry   <= 1'b0;
      r_mvalid   <= 1'b0;
      r_err      <= 1'b0;
      r_iv_en    <= 1'b0;
      r_iv_phase <= 1'b0;
      r_key      <= '0;
      r_iv       <= '0;
      r_iter     <= '0;
      r_gk       <= '0;
    end else begin
      r_err <= w_reject;
      case (r_state)
        ST_IDLE: begin
          if (w_accept_key) begin
            r_key   <= i_key;
            r_iv    <= i_iv;
            r_iv_en <= i_iv_en;
          end else if (w_accept_iv) begin
            // Restore master state so IVMIX runs next cycle
            r_x     <= r_mx;
            r_c     <= r_mc;
            r_carry <= r_mcarry;
            r_iv    <= i_iv;
          end
        end
        ST_LOAD: begin
          r_x        <= w_load_x;
          r_c        <= w_load_c;
          r_carry    <= 1'b0;
          r_mvalid   <= 1'b0;
          r_iter     <= '0;
          r_iv_phase <= 1'b0;
        end
        ST_CNT: begin
          r_c     <= w_cnt_c;
          r_carry <= w_cnt_carry;
          r_gk    <= '0;
        end
        ST_G: begin
          for (int l = 0; l < G_LANES; l++) r_g[w_lane_idx[l]] <= w_lane_g[l];
          r_gk <= r_gk + 3'd1;
        end
        ST_XUPD: begin
          r_x    <= w_xn;
          r_iter <= r_iter + 4'd1;
        end
        ST_CFIX: begin
          r_c      <= w_cfix_c;
          r_mx     <= r_x;
          r_mc     <= w_cfix_c;
          r_mcarry <= r_carry;
          r_mvalid <= 1'b1;
        end
        ST_IVMIX: begin
          r_c        <= w_ivmix_c;
          r_iter     <= '0;
          r_iv_phase <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_busy         = w_busy;
  assign o_done         = w_done;
  assign o_master_valid = r_mvalid;
  assign o_err          = r_err;
  assign o_x_state      = r_x;
  assign o_c_state      = r_c;
  assign o_carry        = r_carry;

endmodule

`default_nettype wire

// File: tb/tb_rabbit_key_iv_setup.sv
//------------------------------------------------------------------------------
// tb_rabbit_key_iv_setup
//   Self-checking bench: four engines (G_LANES = 8, 4, 2, 1) driven in
//   parallel from a vector table, results compared against a behavioural
//   Rabbit model through a scoreboard queue.
//   Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_rabbit_key_iv_setup;

  localparam int NL   = 4;
  localparam int ITER = 4;
  localparam int NV   = 9;

  typedef struct packed {
    logic [7:0][31:0] x;
    logic [7:0][31:0] c;
    logic             cy;
  } st_t;

  typedef struct packed {
    logic [1:0]   op;     // 0 start_key, 1 start_iv, 2 both
    logic [127:0] key;
    logic [63:0]  iv;
    logic         iv_en;
    logic         poke;   // fire extra starts while busy
    logic         early;  // check LOAD / first CNT values
    logic [7:0]   lat;    // expected latency for G_LANES=8
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start_key, start_iv, iv_en;
  logic [127:0] key;
  logic [63:0]  iv;
  logic [NL-1:0] busy, done, mvalid, err, carry;
  logic [NL-1:0][255:0] xs, cs;

  int errors, checks;
  st_t sb[$];
  st_t b_master;
  vec_t vecs[NV];
  vec_t fresh;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NL; gi++) begin : g_dut
    rabbit_key_iv_setup #(.ITER(ITER), .G_LANES(8 >> gi)) u_dut (
      .clk            (clk),
      .rst            (rst),
      .i_start_key    (start_key),
      .i_start_iv     (start_iv),
      .i_key          (key),
      .i_iv           (iv),
      .i_iv_en        (iv_en),
      .o_busy         (busy[gi]),
      .o_done         (done[gi]),
      .o_master_valid (mvalid[gi]),
      .o_err          (err[gi]),
      .o_x_state      (xs[gi]),
      .o_c_state      (cs[gi]),
      .o_carry        (carry[gi])
    );
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] gf(input logic [31:0] x, input logic [31:0] c);
    logic [63:0] u, sq;
    u  = {32'd0, x + c};
    sq = u * u;
    return sq[63:32] ^ sq[31:0];
  endfunction

  function automatic st_t m_load(input logic [127:0] k);
    st_t s;
    logic [15:0] kw [8];
    for (int i = 0; i < 8; i++) kw[i] = k[16*i +: 16];
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) begin
        s.x[j] = {kw[(j+1)%8], kw[j]};
        s.c[j] = {kw[(j+4)%8], kw[(j+5)%8]};
      end else begin
        s.x[j] = {kw[(j+5)%8], kw[(j+4)%8]};
        s.c[j] = {kw[j], kw[(j+1)%8]};
      end
    end
    s.cy = 1'b0;
    return s;
  endfunction

  function automatic st_t m_counter(input st_t s);
    logic [32:0] t;
    logic [31:0] a;
    for (int j = 0; j < 8; j++) begin
      case (j % 3)
        0:       a = 32'h4D34D34D;
        1:       a = 32'hD34D34D3;
        default: a = 32'h34D34D34;
      endcase
      t = {1'b0, s.c[j]} + {1'b0, a} + {32'd0, s.cy};
      s.c[j] = t[31:0];
      s.cy   = t[32];
    end
    return s;
  endfunction

  function automatic st_t m_next(input st_t s_in);
    st_t s;
    logic [31:0] g [8];
    s = m_counter(s_in);
    for (int j = 0; j < 8; j++) g[j] = gf(s.x[j], s.c[j]);
    for (int j = 0; j < 8; j++) begin
      if (j % 2 == 0) s.x[j] = g[j] + rl(g[(j+7)%8], 16) + rl(g[(j+6)%8], 16);
      else            s.x[j] = g[j] + rl(g[(j+7)%8], 8) + g[(j+6)%8];
    end
    return s;
  endfunction

  function automatic st_t m_key(input logic [127:0] k);
    st_t s;
    s = m_load(k);
    for (int n = 0; n < ITER; n++) s = m_next(s);
    for (int j = 0; j < 8; j++) s.c[j] = s.c[j] ^ s.x[(j+4)%8];
    return s;
  endfunction

  function automatic st_t m_iv(input st_t m, input logic [63:0] v);
    st_t s;
    logic [31:0] w [4];
    w[0] = v[31:0];
    w[1] = {v[63:48], v[31:16]};
    w[2] = v[63:32];
    w[3] = {v[47:32], v[15:0]};
    s = m;
    for (int j = 0; j < 8; j++) s.c[j] = s.c[j] ^ w[j%4];
    for (int n = 0; n < ITER; n++) s = m_next(s);
    return s;
  endfunction

  function automatic int exp_lat(input int lanes, input logic [1:0] op, input logic ive);
    int t;
    t = 8 / lanes + 2;
    if (op == 2'd1) return 1 + ITER * t;
    if (ive)        return 3 + 2 * ITER * t;
    return 2 + ITER * t;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input int lane, input logic [519:0] act, input logic [519:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane=%0d got=%0h expected=%0h", name, lane, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    for (int i = 0; i < NL; i++)
      chk(name, i, 520'({xs[i], cs[i], carry[i], busy[i], done[i], mvalid[i], err[i]}), 520'(0));
  endtask

  task automatic do_reject();
    @(posedge clk); #1;
    start_iv = 1'b1;
    iv = 64'h0123456789ABCDEF;
    @(posedge clk); #1;
    start_iv = 1'b0;
    for (int i = 0; i < NL; i++) chk("reject_err_busy", i, 520'({err[i], busy[i], mvalid[i]}), 520'(3'b100));
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) chk("reject_after", i, 520'({err[i], busy[i]}), 520'(2'b00));
  endtask

  task automatic run_vec(input vec_t v);
    st_t e, m, lm, cm;
    logic [NL-1:0] got;
    logic seen_err;
    int lat;
    if (v.op == 2'd1) begin
      e = m_iv(b_master, v.iv);
    end else begin
      m = m_key(v.key);
      b_master = m;
      e = v.iv_en ? m_iv(m, v.iv) : m;
    end
    sb.push_back(e);
    lm = m_load(v.key);
    cm = m_counter(lm);
    @(posedge clk); #1;
    key = v.key; iv = v.iv; iv_en = v.iv_en;
    start_key = (v.op != 2'd1);
    start_iv  = (v.op != 2'd0);
    @(posedge clk); #1;
    // Accepting edge has passed; scramble inputs to prove they were sampled
    start_key = 1'b0; start_iv = 1'b0;
    key = ~v.key; iv = ~v.iv; iv_en = ~v.iv_en;
    got = '0;
    seen_err = 1'b0;
    for (int cyc = 1; cyc <= 200 && got != '1; cyc++) begin
      @(posedge clk); #1;
      start_key = v.poke && (cyc == 3);
      start_iv  = v.poke && (cyc == 3);
      if (|err) seen_err = 1'b1;
      if (v.early && cyc == 1)
        for (int i = 0; i < NL; i++) chk("load_xc", i, 520'({xs[i], cs[i]}), 520'({lm.x, lm.c}));
      if (v.early && cyc == 2) begin
        for (int i = 0; i < NL; i++) chk("first_cnt", i, 520'({cs[i], carry[i]}), 520'({cm.c, cm.cy}));
        if (v.key == 128'd0)
          chk("cnt_const", 0, 520'({cs[0][95:0], carry[0]}), 520'({96'h34D34D34_D34D34D3_4D34D34D, 1'b0}));
      end
      for (int i = 0; i < NL; i++) begin
        if (!got[i] && done[i]) begin
          got[i] = 1'b1;
          lat = (i == 0) ? int'(v.lat) : exp_lat(8 >> i, v.op, v.iv_en);
          chk("latency", i, 520'(cyc), 520'(lat));
          chk("state", i, 520'({xs[i], cs[i], carry[i]}), 520'(sb[0]));
          chk("busy_at_done", i, 520'(busy[i]), 520'(0));
        end
      end
    end
    for (int i = 0; i < NL; i++) chk("done_seen", i, 520'(got[i]), 520'(1));
    chk("no_err", 0, 520'(seen_err), 520'(0));
    e = sb.pop_front();
    start_key = 1'b0; start_iv = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < NL; i++) begin
      chk("idle_after", i, 520'({busy[i], done[i], mvalid[i]}), 520'(3'b001));
      chk("hold", i, 520'({xs[i], cs[i], carry[i]}), 520'(e));
    end
  endtask

  task automatic mid_reset(input logic [127:0] k);
    @(posedge clk); #1;
    key = k; iv_en = 1'b0; start_key = 1'b1;
    @(posedge clk); #1;
    start_key = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    for (int i = 0; i < NL; i++) chk("busy_before_rst", i, 520'(busy[i]), 520'(1));
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog lane=0 got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    errors = 0; checks = 0;
    b_master = '0;
    rst = 1'b1;
    start_key = 1'b0; start_iv = 1'b0; iv_en = 1'b0;
    key = '0; iv = '0;

    vecs[0] = '{op:2'd0, key:128'd0, iv:64'd0, iv_en:1'b0, poke:1'b0, early:1'b1, lat:8'd14};
    vecs[1] = '{op:2'd1, key:128'd0, iv:64'h0123456789ABCDEF, iv_en:1'b0, poke:1'b0, early:1'b0, lat:8'd13};
    vecs[2] = '{op:2'd0, key:128'd0, iv:64'h0123456789ABCDEF, iv_en:1'b1, poke:1'b0, early:1'b0, lat:8'd27};
    vecs[3] = '{op:2'd0, key:128'h912813292E3D36FE3BFC62F1DC51C3AC, iv:64'd0, iv_en:1'b0,
                poke:1'b1, early:1'b1, lat:8'd14};
    vecs[4] = '{op:2'd1, key:128'd0, iv:64'h0123456789ABCDEF, iv_en:1'b0, poke:1'b0, early:1'b0, lat:8'd13};
    vecs[5] = '{op:2'd1, key:128'd0, iv:64'hFEDCBA9876543210, iv_en:1'b0, poke:1'b0, early:1'b0, lat:8'd13};
    vecs[6] = '{op:2'd2, key:{$urandom, $urandom, $urandom, $urandom}, iv:{$urandom, $urandom},
                iv_en:1'b1, poke:1'b0, early:1'b0, lat:8'd27};
    vecs[7] = '{op:2'd0, key:{$urandom, $urandom, $urandom, $urandom}, iv:64'hC373F575C1267E59,
                iv_en:1'b1, poke:1'b1, early:1'b0, lat:8'd27};
    vecs[8] = '{op:2'd1, key:128'd0, iv:{$urandom, $urandom}, iv_en:1'b0, poke:1'b0, early:1'b0, lat:8'd13};
    fresh   = '{op:2'd0, key:{$urandom, $urandom, $urandom, $urandom}, iv:64'd0, iv_en:1'b0,
                poke:1'b0, early:1'b1, lat:8'd14};

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_held");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("reset_released");

    do_reject();

    for (int n = 0; n < NV; n++) run_vec(vecs[n]);

    mid_reset(128'h000102030405060708090A0B0C0D0E0F);
    do_reject();
    run_vec(fresh);

    chk("scoreboard_empty", 0, 520'(sb.size()), 520'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rabbit_key_iv_setup.md
Name: rabbit_key_iv_setup

Overview:
- Complete Rabbit initialisation engine: key expansion, ITER next-state iterations, counter re-mix, and optional 64-bit IV setup.
- Saves the post-key "master" state, so new IVs can be applied without redoing key setup.
- Sits between the key/IV register interface and the keystream generator, which takes x_state/c_state/carry on done.
- G_LANES sets the number of g-function units, trading area for latency.

Parameters:
- ITER, 4, next-state iterations per phase (key phase and IV phase); legal range 1..15.
- G_LANES, 8, g-function units; legal values 1, 2, 4, 8; P = 8/G_LANES cycles per G sweep.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start_key  in  1  pulse: begin key setup from key (plus IV setup if iv_en)
- start_iv  in  1  pulse: begin IV setup from saved master state
- key  in  128  K_i = key[16i+15:16i]; sampled on accepted start_key
- iv  in  64  sampled on any accepted start
- iv_en  in  1  sampled with start_key; 1 = also run the IV phase
- busy  out  1  high from acceptance until done
- done  out  1  one-cycle pulse; state outputs valid
- master_valid  out  1  saved master state present
- err  out  1  one-cycle pulse: start_iv rejected
- x_state  out  256  X_j at [32j+31:32j]
- c_state  out  256  C_j at [32j+31:32j]
- carry  out  1  counter carry bit phi

Behaviour:
- Reset (async, any state): every output and internal register goes to 0, FSM goes to IDLE, master_valid=0.
- Starts:
  - Accepted only in IDLE. Starts while busy are ignored, with no err.
  - start_key wins if both are high.
  - start_iv with master_valid=0 is rejected: err=1 for one cycle, state unchanged.
- FSM: IDLE -> LOAD -> {CNT -> G[0..P-1] -> XUPD} x ITER -> CFIX -> (IVMIX -> {CNT -> G -> XUPD} x ITER) -> DONE -> IDLE.
- LOAD (start_key):
  - even j: X_j={K_(j+1),K_j}, C_j={K_(j+4),K_(j+5)}; odd j: X_j={K_(j+5),K_(j+4)}, C_j={K_j,K_(j+1)}; indices mod 8. carry=0.
  - LOAD also sets master_valid=0.
- CNT: C_j = C_j + A_j + carry_in, mod 2^32, chained j=0..7.
  - carry_in for j=0 is the carry register; for j>0 it is the carry-out of C_(j-1).
  - Final carry-out goes into the carry register.
  - A = 4D34D34D, D34D34D3, 34D34D34, repeating.
- G cycle k: for lanes l=0..G_LANES-1 and j=k*G_LANES+l: G_j = hi32(sq) XOR lo32(sq), where sq = (X_j+C_j mod 2^32)^2 as 64 bits. G_j is registered.
- XUPD, with <<< meaning rotate left:
  - X0=G0+(G7<<<16)+(G6<<<16); X1=G1+(G0<<<8)+G7
  - X2=G2+(G1<<<16)+(G0<<<16); X3=G3+(G2<<<8)+G1
  - X4=G4+(G3<<<16)+(G2<<<16); X5=G5+(G4<<<8)+G3
  - X6=G6+(G5<<<16)+(G4<<<16); X7=G7+(G6<<<8)+G5
  - All sums mod 2^32.
- CFIX: C_j ^= X_((j+4) mod 8). The resulting X/C/carry are copied to the master registers; master_valid=1.
- start_iv acceptance: the master state is copied into the working state at the acceptance edge; the next cycle is IVMIX.
- IVMIX, with I0=iv[31:0], I1={iv[63:48],iv[31:16]}, I2=iv[63:32], I3={iv[47:32],iv[15:0]}:
  - C0^=I0, C1^=I1, C2^=I2, C3^=I3, C4^=I0, C5^=I1, C6^=I2, C7^=I3.
  - X and carry are unchanged.
- DONE: done=1 for one cycle, busy drops in the same cycle. Outputs hold until the next LOAD or IV copy.
- Latency from the accepting edge to the done cycle, with per-iteration cost T=P+2:
  - key only: 2+ITER*T cycles (defaults: 14);
  - key+IV: 3+2*ITER*T (defaults: 27);
  - start_iv: 1+ITER*T (defaults: 13).
- During busy, x_state/c_state show the working registers and are not guaranteed stable.

Decomposition:
- rabbit_pkg holds:
  - the A_j constants and the ITER default;
  - FSM state encoding;
  - rotl32 function;
  - key-word and IV-word extraction functions.
- Sub-module rabbit_g_func: combinational 32-bit g-function (add, 64-bit square, fold), instantiated G_LANES times.
- The top level holds the FSM, the lane mux, X/C/G/master registers and the counter chain.

Test Plan:
- Reset/counter: key=0, start_key, iv_en=0, defaults.
  - After LOAD, all X/C=0.
  - After the first CNT, C0=4D34D34D, C1=D34D34D3, C2=34D34D34, carry=0.
  - done at cycle 14, master_valid=1.
- Golden state: random keys plus the Rabbit reference test keys; compare x_state/c_state/carry at done against the C model, for G_LANES=8,4,2,1. Latencies must be 14, 18, 26, 42 cycles.
- IV reuse:
  - start_key(K, iv_en=0), then start_iv(IV=0x0123456789ABCDEF): must equal start_key(K, iv_en=1, same IV).
  - start_iv done at cycle 13.
  - A second start_iv with a different IV starts from the unchanged master state.
- Rejection: after reset, start_iv -> err pulse, busy stays 0. start_key while busy -> ignored, result and latency unchanged.
- Mid-operation reset: assert rst at cycle 7 of key setup -> all outputs 0, master_valid=0, IDLE. A fresh start_key then completes normally.
- Simultaneous start_key and start_iv in IDLE -> key setup runs; no err.
